// File: rtl/mem_upload_pkg.sv
// Shared definitions for the memory dump engine: FSM state encoding,
// default frame sync byte and header length.
// Imported by mem_upload and mem_upload_frame.
package mem_upload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_WAIT,
    ST_PUSH,
    ST_SUM,
    ST_FIN
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h5A;
  localparam int         HDR_LEN       = 5;

endpackage

// File: rtl/mem_upload_frame.sv
// Frame header/checksum byte source for mem_upload.
// Ports: clear captures addr/length and zeroes index and checksum; hdr_adv steps
// the header index; sum_add accumulates sum_byte; hdr_byte/csum/hdr_last out.
module mem_upload_frame
  import mem_upload_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] start_addr,
  input  logic [15:0] length,
  input  logic        hdr_adv,
  input  logic        sum_add,
  input  logic [7:0]  sum_byte,
  output logic [7:0]  hdr_byte,
  output logic [7:0]  csum,
  output logic        hdr_last
);

  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;

  always_comb begin
    idx_d  = idx_q;
    sum_d  = sum_q;
    addr_d = addr_q;
    len_d  = len_q;
    if (clear) begin
      idx_d  = 3'd0;
      sum_d  = 8'd0;
      addr_d = start_addr;
      len_d  = length;
    end else begin
      if (hdr_adv) idx_d = idx_q + 3'd1;
      if (sum_add) sum_d = sum_q + sum_byte;  // wraps modulo 256
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 3'd0;
      sum_q  <= 8'd0;
      addr_q <= 16'd0;
      len_q  <= 16'd0;
    end else begin
      idx_q  <= idx_d;
      sum_q  <= sum_d;
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  always_comb begin
    hdr_byte = 8'd0;
    case (idx_q)
      3'd0: hdr_byte = SYNC_BYTE;
      3'd1: hdr_byte = addr_q[15:8];
      3'd2: hdr_byte = addr_q[7:0];
      3'd3: hdr_byte = len_q[15:8];
      3'd4: hdr_byte = len_q[7:0];
      default: hdr_byte = 8'd0;
    endcase
  end

  assign csum     = sum_q;
  assign hdr_last = (idx_q == 3'(HDR_LEN - 1));

endmodule

// File: rtl/mem_upload.sv
// RAM-to-host dump engine: on START streams SYNC, addr, len, N RAM bytes, checksum.
// Ports: RAM read port (RAM_EN/RAM_ADDR/RAM_DOUT), FIFO write side (F2H_*),
// command START/START_ADDR/LENGTH/ABORT, status BUSY and DONE pulse.
module mem_upload
  import mem_upload_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         RAM_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [15:0] START_ADDR,
  input  logic [15:0] LENGTH,
  input  logic        ABORT,
  output logic        RAM_EN,
  output logic [15:0] RAM_ADDR,
  input  logic [7:0]  RAM_DOUT,
  output logic [7:0]  F2H_DATA,
  output logic        F2H_WR,
  input  logic        F2H_FULL,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [16:0] rem_q, rem_d;      // 17 bits so LENGTH=0 can mean 65536
  logic [1:0]  wait_q, wait_d;
  logic [7:0]  dat_q, dat_d;
  logic        ram_en_q, ram_en_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  f2h_data_q, f2h_data_d;
  logic        f2h_wr_q, f2h_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        clear, hdr_adv, sum_add, hdr_last;
  logic [7:0]  hdr_byte, csum;

  mem_upload_frame #(.SYNC_BYTE(SYNC_BYTE)) u_frame (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clear     (clear),
    .start_addr(START_ADDR),
    .length    (LENGTH),
    .hdr_adv   (hdr_adv),
    .sum_add   (sum_add),
    .sum_byte  (dat_q),
    .hdr_byte  (hdr_byte),
    .csum      (csum),
    .hdr_last  (hdr_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wait_d     = wait_q;
    dat_d      = dat_q;
    f2h_data_d = f2h_data_q;
    f2h_wr_d   = 1'b0;
    done_d     = 1'b0;
    clear      = 1'b0;
    hdr_adv    = 1'b0;
    sum_add    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          clear   = 1'b1;
          addr_d  = START_ADDR;
          rem_d   = {(LENGTH == 16'h0000), LENGTH};
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (ABORT) begin
          state_d = ST_SUM;
        end else if (!F2H_FULL) begin
          f2h_wr_d   = 1'b1;
          f2h_data_d = hdr_byte;
          hdr_adv    = 1'b1;
          if (hdr_last) state_d = ST_RD;
        end
      end
      ST_RD: begin
        wait_d  = 2'd0;
        state_d = ABORT ? ST_SUM : ST_WAIT;
      end
      ST_WAIT: begin
        if (ABORT) begin
          state_d = ST_SUM;
        end else if (wait_q == WAIT_LAST) begin
          dat_d   = RAM_DOUT;
          state_d = ST_PUSH;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_PUSH: begin
        // Abort takes priority: the pending byte is neither written nor summed.
        if (ABORT) begin
          state_d = ST_SUM;
        end else if (!F2H_FULL) begin
          f2h_wr_d   = 1'b1;
          f2h_data_d = dat_q;
          sum_add    = 1'b1;
          addr_d     = addr_q + 16'd1;
          rem_d      = rem_q - 17'd1;
          state_d    = (rem_q == 17'd1) ? ST_SUM : ST_RD;
        end
      end
      ST_SUM: begin
        if (!F2H_FULL) begin
          f2h_wr_d   = 1'b1;
          f2h_data_d = csum;
          state_d    = ST_FIN;
        end
      end
      ST_FIN: begin
        // DONE lands the cycle after the checksum strobe.
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM outputs are registered, so they are set on the edge entering RD.
  assign ram_en_d   = (state_d == ST_RD);
  assign ram_addr_d = (state_d == ST_RD) ? addr_d : ram_addr_q;
  assign busy_d     = (state_d != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      addr_q     <= 16'd0;
      rem_q      <= 17'd0;
      wait_q     <= 2'd0;
      dat_q      <= 8'd0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= 16'd0;
      f2h_data_q <= 8'd0;
      f2h_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wait_q     <= wait_d;
      dat_q      <= dat_d;
      ram_en_q   <= ram_en_d;
      ram_addr_q <= ram_addr_d;
      f2h_data_q <= f2h_data_d;
      f2h_wr_q   <= f2h_wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign RAM_EN   = ram_en_q;
  assign RAM_ADDR = ram_addr_q;
  assign F2H_DATA = f2h_data_q;
  assign F2H_WR   = f2h_wr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule
